// File: rtl/stage_if_if.sv
// Fetch-stage bus bundle: redirect input, IF/ID handshake and byte-wide memory port.
// The master modport is the fetch stage; the slave modport is its environment.
interface stage_if_if;
  logic        branch_enable_i;
  logic [31:0] branch_addr_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [7:0]  mem_data_i;

  modport master (
    input  branch_enable_i, branch_addr_i, id_ready_i, mem_valid_i, mem_data_i,
    output if_valid_o, pc_o, inst_o, mem_req_o, mem_addr_o
  );

  modport slave (
    output branch_enable_i, branch_addr_i, id_ready_i, mem_valid_i, mem_data_i,
    input  if_valid_o, pc_o, inst_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/stage_if.sv
// RV32I instruction-fetch stage: assembles each instruction from four little-endian
// byte reads and holds {pc, inst} for the IF/ID register until accepted or redirected.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy,
  stage_if_if.master   bus
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  state_e      state_q,    state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] buf_q,      buf_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] inst_q,     inst_d;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    if_valid_d = if_valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;

    if (rdy) begin
      if (bus.branch_enable_i) begin
        // Redirect wins over a returning byte and over an accept in the same cycle.
        state_d    = S_FETCH;
        fetch_pc_d = bus.branch_addr_i;
        byte_cnt_d = 2'd0;
        if_valid_d = 1'b0;
      end else begin
        unique case (state_q)
          S_FETCH: begin
            if (bus.mem_valid_i) begin
              if (byte_cnt_q == 2'd3) begin
                state_d    = S_HOLD;
                inst_d     = {bus.mem_data_i, buf_q};
                pc_d       = fetch_pc_q;
                if_valid_d = 1'b1;
                byte_cnt_d = 2'd0;
              end else begin
                unique case (byte_cnt_q)
                  2'd0:    buf_d[7:0]   = bus.mem_data_i;
                  2'd1:    buf_d[15:8]  = bus.mem_data_i;
                  default: buf_d[23:16] = bus.mem_data_i;
                endcase
                byte_cnt_d = byte_cnt_q + 2'd1;
              end
            end
          end
          S_HOLD: begin
            if (bus.id_ready_i) begin
              state_d    = S_FETCH;
              fetch_pc_d = fetch_pc_q + 32'd4;
              if_valid_d = 1'b0;
            end
          end
          default: state_d = S_FETCH;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      byte_cnt_q <= 2'd0;
      buf_q      <= '0;
      if_valid_q <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      if_valid_q <= if_valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

  // NOTE: the request is gated by rst_n so the bus is quiet while reset is held,
  // yet the first request still appears in the first cycle after release.
  assign bus.mem_req_o  = rst_n & rdy & (state_q == S_FETCH);
  assign bus.mem_addr_o = rst_n ? (fetch_pc_q + {30'd0, byte_cnt_q}) : 32'd0;
  assign bus.if_valid_o = if_valid_q;
  assign bus.pc_o       = pc_q;
  assign bus.inst_o     = inst_q;

endmodule

// File: tb/tb_stage_if.sv
// Directed, table-driven bench for stage_if: one record per cycle of inputs and
// expected outputs, plus a hand-written asynchronous-reset sequence.
module tb_stage_if;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;

  stage_if_if bus ();

  stage_if #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        br_en;
    logic [31:0] br_addr;
    logic        id_rdy;
    logic        mv;
    logic [7:0]  md;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  localparam int NV = 39;
  vec_t vecs [NV];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic be, input logic [31:0] ba,
                       input logic ir, input logic mv, input logic [7:0] md);
    rdy                 = r;
    bus.branch_enable_i = be;
    bus.branch_addr_i   = ba;
    bus.id_ready_i      = ir;
    bus.mem_valid_i     = mv;
    bus.mem_data_i      = md;
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst, input logic req, input logic [31:0] addr);
    check({tag, ".valid"}, {31'd0, bus.if_valid_o}, {31'd0, v});
    check({tag, ".pc"},    bus.pc_o,   pc);
    check({tag, ".inst"},  bus.inst_o, inst);
    check({tag, ".req"},   {31'd0, bus.mem_req_o}, {31'd0, req});
    if (req) check({tag, ".addr"}, bus.mem_addr_o, addr);
  endtask

  function automatic vec_t mk(input logic r, input logic be, input logic [31:0] ba,
                              input logic ir, input logic mv, input logic [7:0] md,
                              input logic ev, input logic [31:0] ep, input logic [31:0] ei,
                              input logic eq, input logic [31:0] ea);
    vec_t t;
    t.rdy = r; t.br_en = be; t.br_addr = ba; t.id_rdy = ir; t.mv = mv; t.md = md;
    t.e_valid = ev; t.e_pc = ep; t.e_inst = ei; t.e_req = eq; t.e_addr = ea;
    return t;
  endfunction

  initial begin
    //              rdy be  br_addr        ir  mv  md     ev  pc             inst           rq  addr
    // Fetch at 0: 13 00 00 00, accepted immediately.
    vecs[0]  = mk(1, 0, 32'h0,          0, 1, 8'h13,  0, 32'h0,         32'h0,         1, 32'h0);
    vecs[1]  = mk(1, 0, 32'h0,          0, 1, 8'h00,  0, 32'h0,         32'h0,         1, 32'h1);
    vecs[2]  = mk(1, 0, 32'h0,          0, 1, 8'h00,  0, 32'h0,         32'h0,         1, 32'h2);
    vecs[3]  = mk(1, 0, 32'h0,          0, 1, 8'h00,  0, 32'h0,         32'h0,         1, 32'h3);
    vecs[4]  = mk(1, 0, 32'h0,          1, 0, 8'h00,  1, 32'h0,         32'h13,        0, 32'h0);
    // Fetch at 4: 93 00 10 00, held three cycles (stray mem_valid ignored), then accepted.
    vecs[5]  = mk(1, 0, 32'h0,          0, 1, 8'h93,  0, 32'h0,         32'h13,        1, 32'h4);
    vecs[6]  = mk(1, 0, 32'h0,          0, 1, 8'h00,  0, 32'h0,         32'h13,        1, 32'h5);
    vecs[7]  = mk(1, 0, 32'h0,          0, 1, 8'h10,  0, 32'h0,         32'h13,        1, 32'h6);
    vecs[8]  = mk(1, 0, 32'h0,          0, 1, 8'h00,  0, 32'h0,         32'h13,        1, 32'h7);
    vecs[9]  = mk(1, 0, 32'h0,          0, 1, 8'hEE,  1, 32'h4,         32'h0010_0093, 0, 32'h0);
    vecs[10] = mk(1, 0, 32'h0,          0, 0, 8'h00,  1, 32'h4,         32'h0010_0093, 0, 32'h0);
    vecs[11] = mk(1, 0, 32'h0,          0, 0, 8'h00,  1, 32'h4,         32'h0010_0093, 0, 32'h0);
    vecs[12] = mk(1, 0, 32'h0,          1, 0, 8'h00,  1, 32'h4,         32'h0010_0093, 0, 32'h0);
    // Fetch at 8 aborted after two bytes by a redirect to 0x100 (third byte discarded).
    vecs[13] = mk(1, 0, 32'h0,          0, 1, 8'hAA,  0, 32'h4,         32'h0010_0093, 1, 32'h8);
    vecs[14] = mk(1, 0, 32'h0,          0, 1, 8'hBB,  0, 32'h4,         32'h0010_0093, 1, 32'h9);
    vecs[15] = mk(1, 1, 32'h100,        0, 1, 8'hCC,  0, 32'h4,         32'h0010_0093, 1, 32'hA);
    // Fetch at 0x100: 37 12 00 00 with a 4-cycle rdy=0 pause after byte 0.
    vecs[16] = mk(1, 0, 32'h0,          0, 1, 8'h37,  0, 32'h4,         32'h0010_0093, 1, 32'h100);
    vecs[17] = mk(0, 0, 32'h0,          0, 1, 8'hFF,  0, 32'h4,         32'h0010_0093, 0, 32'h0);
    vecs[18] = mk(0, 1, 32'h300,        0, 0, 8'hFF,  0, 32'h4,         32'h0010_0093, 0, 32'h0);
    vecs[19] = mk(0, 0, 32'h0,          1, 1, 8'hFF,  0, 32'h4,         32'h0010_0093, 0, 32'h0);
    vecs[20] = mk(0, 0, 32'h0,          0, 0, 8'hFF,  0, 32'h4,         32'h0010_0093, 0, 32'h0);
    vecs[21] = mk(1, 0, 32'h0,          0, 1, 8'h12,  0, 32'h4,         32'h0010_0093, 1, 32'h101);
    vecs[22] = mk(1, 0, 32'h0,          0, 1, 8'h00,  0, 32'h4,         32'h0010_0093, 1, 32'h102);
    vecs[23] = mk(1, 0, 32'h0,          0, 1, 8'h00,  0, 32'h4,         32'h0010_0093, 1, 32'h103);
    // Redirect to 0x40 coinciding with an accept: the held instruction is dropped.
    vecs[24] = mk(1, 1, 32'h40,         1, 0, 8'h00,  1, 32'h100,       32'h0000_1237, 0, 32'h0);
    vecs[25] = mk(1, 0, 32'h0,          0, 1, 8'h13,  0, 32'h100,       32'h0000_1237, 1, 32'h40);
    vecs[26] = mk(1, 0, 32'h0,          0, 1, 8'h05,  0, 32'h100,       32'h0000_1237, 1, 32'h41);
    vecs[27] = mk(1, 0, 32'h0,          0, 1, 8'h00,  0, 32'h100,       32'h0000_1237, 1, 32'h42);
    vecs[28] = mk(1, 0, 32'h0,          0, 1, 8'h00,  0, 32'h100,       32'h0000_1237, 1, 32'h43);
    vecs[29] = mk(1, 0, 32'h0,          1, 0, 8'h00,  1, 32'h40,        32'h0000_0513, 0, 32'h0);
    // Misaligned redirect, address stable while no data returns, then redirect near the top.
    vecs[30] = mk(1, 1, 32'h203,        0, 0, 8'h00,  0, 32'h40,        32'h0000_0513, 1, 32'h44);
    vecs[31] = mk(1, 0, 32'h0,          0, 0, 8'h00,  0, 32'h40,        32'h0000_0513, 1, 32'h203);
    vecs[32] = mk(1, 1, 32'hFFFF_FFFE,  0, 1, 8'h77,  0, 32'h40,        32'h0000_0513, 1, 32'h203);
    vecs[33] = mk(1, 0, 32'h0,          0, 1, 8'h01,  0, 32'h40,        32'h0000_0513, 1, 32'hFFFF_FFFE);
    vecs[34] = mk(1, 0, 32'h0,          0, 1, 8'h02,  0, 32'h40,        32'h0000_0513, 1, 32'hFFFF_FFFF);
    vecs[35] = mk(1, 0, 32'h0,          0, 1, 8'h03,  0, 32'h40,        32'h0000_0513, 1, 32'h0);
    vecs[36] = mk(1, 0, 32'h0,          0, 1, 8'h04,  0, 32'h40,        32'h0000_0513, 1, 32'h1);
    vecs[37] = mk(1, 0, 32'h0,          1, 0, 8'h00,  1, 32'hFFFF_FFFE, 32'h0403_0201, 0, 32'h0);
    vecs[38] = mk(1, 0, 32'h0,          0, 0, 8'h00,  0, 32'hFFFF_FFFE, 32'h0403_0201, 1, 32'h2);

    // Reset state.
    rst_n = 1'b0;
    drive(1, 0, 32'h0, 0, 0, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    check_all("reset", 0, 32'h0, 32'h0, 0, 32'h0);
    check("reset.addr", bus.mem_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rdy, vecs[i].br_en, vecs[i].br_addr, vecs[i].id_rdy, vecs[i].mv, vecs[i].md);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst,
                vecs[i].e_req, vecs[i].e_addr);
    end

    // Asynchronous reset in the middle of a fetch at 0x20.
    @(negedge clk);
    drive(1, 1, 32'h20, 0, 0, 8'h00);
    @(negedge clk);
    drive(1, 0, 32'h0, 0, 1, 8'h11);
    #1 check("rst_seq.addr0", bus.mem_addr_o, 32'h20);
    @(negedge clk);
    drive(1, 0, 32'h0, 0, 1, 8'h22);
    #1 check("rst_seq.addr1", bus.mem_addr_o, 32'h21);
    @(negedge clk);
    drive(1, 0, 32'h0, 0, 0, 8'h00);
    #1 check("rst_seq.addr2", bus.mem_addr_o, 32'h22);
    #1 rst_n = 1'b0;
    #1;
    check_all("rst_async", 0, 32'h0, 32'h0, 0, 32'h0);
    check("rst_async.addr", bus.mem_addr_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_all("rst_rel", 0, 32'h0, 32'h0, 1, 32'h0);

    // Fresh fetch at RESET_PC: 33 85 A5 00; stale partial bytes must not leak in.
    for (int b = 0; b < 4; b++) begin
      logic [7:0] bytes [4];
      bytes[0] = 8'h33; bytes[1] = 8'h85; bytes[2] = 8'hA5; bytes[3] = 8'h00;
      @(negedge clk);
      drive(1, 0, 32'h0, 0, 1, bytes[b]);
      #1 check_all($sformatf("rst_fetch%0d", b), 0, 32'h0, 32'h0, 1, b);
    end
    @(negedge clk);
    drive(1, 0, 32'h0, 0, 0, 8'h00);
    #1 check_all("rst_hold", 1, 32'h0, 32'h00A5_8533, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_if.md
Name: stage_if

Overview:
- Instruction-fetch stage at the front of the 5-stage RV32I pipeline.
- Fetches each 32-bit instruction from the byte-wide memory controller as 4 little-endian byte reads.
- Presents {pc, inst} to the IF/ID register through a valid/ready handshake.
- Redirects to the target that the decode stage reports with branch_enable/branch_addr, discarding any fetch already in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
rdy  input  1  global ready; low freezes the block
branch_enable_i  input  1  single-cycle redirect request from decode
branch_addr_i  input  32  redirect target
id_ready_i  input  1  IF/ID accepts the held instruction this cycle
if_valid_o  output  1  pc_o/inst_o hold a complete instruction
pc_o  output  32  address of the presented instruction
inst_o  output  32  presented instruction
mem_req_o  output  1  byte read request to memory controller
mem_addr_o  output  32  byte address of the request
mem_valid_i  input  1  mem_data_i is the byte at the current mem_addr_o
mem_data_i  input  8  returned byte

Behaviour:
- Reset (rst_n low, async): state=FETCH, fetch_pc=RESET_PC, byte_cnt=0, inst buffer=0, if_valid_o=0, pc_o=0, inst_o=0, mem_req_o=0, mem_addr_o=0.
  - First request is issued on the first enabled cycle after release.
- States:
  - FETCH: mem_req_o=1, mem_addr_o=fetch_pc+byte_cnt (32-bit wrap).
    - On mem_valid_i: buffer[8*byte_cnt+7 : 8*byte_cnt] <= mem_data_i.
    - If byte_cnt<3: byte_cnt++.
    - If byte_cnt==3: go to HOLD with inst_o={mem_data_i, buffer[23:0]}, pc_o=fetch_pc, if_valid_o=1, byte_cnt=0.
  - HOLD: if_valid_o=1, mem_req_o=0, outputs stable.
    - On id_ready_i: fetch_pc <= fetch_pc+4, if_valid_o=0, go to FETCH.
- Memory protocol:
  - One outstanding byte at a time.
  - mem_addr_o is stable while mem_req_o=1 until mem_valid_i, except on redirect.
  - The controller accepts an address change at any cycle and returns data only for the current address.
  - mem_valid_i is ignored when mem_req_o=0.
- Latency: best case 4 cycles from first request to if_valid_o=1 (mem_valid_i every cycle). A back-to-back accept costs one HOLD cycle per instruction.
- Redirect (branch_enable_i=1 with rdy=1) has priority over every other event, in any state:
  - fetch_pc <= branch_addr_i, byte_cnt <= 0, if_valid_o <= 0, state <= FETCH.
  - A byte returned in the same cycle is discarded.
  - A held instruction is dropped even if id_ready_i=1 that cycle; no handshake completes.
  - The new request appears the next cycle with mem_addr_o=branch_addr_i.
- Misaligned targets (branch_addr_i[1:0]!=0) are fetched as given; no trap.
- rdy=0:
  - mem_req_o=0 combinationally.
  - All registers hold, including byte_cnt and the partial buffer.
  - mem_valid_i, branch_enable_i and id_ready_i are ignored.
  - Fetch resumes at the same byte when rdy returns.
- Reset mid-fetch or mid-hold: immediate return to reset values; partial data is lost.
- pc_o/inst_o are registered; they change only on entry to HOLD or reset.

Test Plan:
1. Release reset, memory returns 0x13,0x00,0x00,0x00 on consecutive cycles, id_ready_i=1 -> mem_addr_o 0,1,2,3; if_valid_o=1 cycle 5 with pc_o=0, inst_o=0x00000013; next request addr 4.
2. Instruction held, id_ready_i=0 for 3 cycles then 1 -> if_valid_o stays 1, pc_o/inst_o unchanged, mem_req_o=0 during hold; after accept mem_addr_o=4.
3. branch_enable_i=1, branch_addr_i=0x100 after 2 bytes of fetch at 0x8 -> next cycle mem_addr_o=0x100, byte_cnt 0; old bytes never appear in inst_o.
4. branch_enable_i=1 (addr 0x40) concurrent with id_ready_i=1 in HOLD -> if_valid_o falls, next fetch at 0x40, pc_o of next valid = 0x40.
5. rdy=0 for 4 cycles after byte 1, mem_valid_i toggling -> mem_req_o=0, no capture; on rdy=1 resumes at fetch_pc+1, correct inst assembled.
6. rst_n pulsed low mid-fetch at pc 0x20 -> outputs zero asynchronously; after release fetch restarts at RESET_PC.
